// File: rtl/i2c_slave_regfile.sv
// I2C target with 7-bit address, auto-incrementing register pointer,
// burst read/write to an application register bank and SCL stretching.
module i2c_slave_regfile #(
  parameter logic [6:0] SLV_ADDR   = 7'h42,
  parameter int         NREGS      = 16,
  parameter int         SYNC       = 2,
  parameter bit         STRETCH_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sda_in,
  input  logic                     scl_in,
  output logic                     sda_out,
  output logic                     scl_out,
  output logic                     wr_en,
  output logic [$clog2(NREGS)-1:0] wr_addr,
  output logic [7:0]               wr_data,
  output logic [$clog2(NREGS)-1:0] rd_addr,
  input  logic [7:0]               rd_data,
  input  logic                     app_busy,
  output logic                     bus_active
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] PONE = 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WR_BYTE, RD_BYTE, WAIT_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [SYNC-1:0] sda_sq, scl_sq;
  logic [3:0]      cnt_q, cnt_d;
  logic [6:0]      sh_q, sh_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            sda_q, sda_d;
  logic            rw_q, rw_d;
  logic            act_q, act_d;
  logic            wen_q, wen_d;
  logic            str_q, str_d;

  logic sda_s, sda_p, scl_s, scl_p;
  logic scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_sq <= '1;
      scl_sq <= '1;
    end else begin
      sda_sq <= {sda_sq[SYNC-2:0], sda_in};
      scl_sq <= {scl_sq[SYNC-2:0], scl_in};
    end
  end

  assign sda_s    = sda_sq[SYNC-2];
  assign sda_p    = sda_sq[SYNC-1];
  assign scl_s    = scl_sq[SYNC-2];
  assign scl_p    = scl_sq[SYNC-1];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start_c  = scl_s & sda_p & ~sda_s;
  assign stop_c   = scl_s & ~sda_p & sda_s;
  assign rx       = {sh_q, sda_s};

  // cnt counts SCL rises: 0..7 data, 8 = ACK bit, 9 = ACK sampled
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    sda_d   = sda_q;
    rw_d    = rw_q;
    act_d   = act_q;
    wen_d   = 1'b0;
    if (start_c) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      act_d   = 1'b1;
      sda_d   = 1'b1;
    end else if (stop_c) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      act_d   = 1'b0;
      sda_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, WAIT_STOP: ;
        ADDR: begin
          if (scl_rise) begin
            sh_d  = rx[6:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (rx[7:1] == SLV_ADDR) begin
                state_d = ADDR_ACK;
                rw_d    = rx[0];
              end else begin
                state_d = IDLE;
                cnt_d   = 4'd0;
              end
            end
          end
        end
        ADDR_ACK, PTR, WR_BYTE: begin
          if (scl_rise) begin
            if (cnt_q < 4'd8) begin
              sh_d  = rx[6:0];
              cnt_d = cnt_q + 4'd1;
              if (cnt_q == 4'd7 && state_q == PTR)
                ptr_d = rx[AW-1:0];
              if (cnt_q == 4'd7 && state_q == WR_BYTE) begin
                wen_d   = 1'b1;
                waddr_d = ptr_q;
                wdata_d = rx;
              end
            end else begin
              cnt_d = 4'd9;
            end
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_d = 1'b0;
            end else if (cnt_q == 4'd9) begin
              sda_d = 1'b1;
              cnt_d = 4'd0;
              if (state_q == ADDR_ACK && rw_q) begin
                state_d = RD_BYTE;
                sh_d    = rd_data[6:0];
                sda_d   = rd_data[7];
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else if (state_q == PTR) begin
                state_d = WR_BYTE;
              end else begin
                ptr_d = ptr_q + PONE;
              end
            end
          end
        end
        RD_BYTE: begin
          if (scl_rise) begin
            if (cnt_q < 4'd8) begin
              cnt_d = cnt_q + 4'd1;
            end else if (!sda_s) begin
              cnt_d = 4'd9;
              ptr_d = ptr_q + PONE;
            end else begin
              state_d = WAIT_STOP;
              cnt_d   = 4'd0;
              sda_d   = 1'b1;
            end
          end else if (scl_fall) begin
            if (cnt_q == 4'd9) begin
              sh_d  = rd_data[6:0];
              sda_d = rd_data[7];
              cnt_d = 4'd0;
            end else if (cnt_q == 4'd8) begin
              sda_d = 1'b1;
            end else if (cnt_q != 4'd0) begin
              sh_d  = {sh_q[5:0], 1'b0};
              sda_d = sh_q[6];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stretch starts only on the ACK falling edge, when SCL is already low
  assign str_d = STRETCH_EN && app_busy && !scl_s &&
                 (str_q || (scl_fall && cnt_q == 4'd9));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= '0;
      ptr_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      sda_q   <= 1'b1;
      rw_q    <= 1'b0;
      act_q   <= 1'b0;
      wen_q   <= 1'b0;
      str_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      sda_q   <= sda_d;
      rw_q    <= rw_d;
      act_q   <= act_d;
      wen_q   <= wen_d;
      str_q   <= str_d;
    end
  end

  assign sda_out    = sda_q;
  assign scl_out    = STRETCH_EN ? ~str_q : 1'b1;
  assign wr_en      = wen_q;
  assign wr_addr    = waddr_q;
  assign wr_data    = wdata_q;
  assign rd_addr    = ptr_q;
  assign bus_active = act_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: a bit-banged I2C master on a wired-AND bus drives the
// target; register bank model is reg[i] = i + 0x10.
module tb_i2c_slave_regfile;

  localparam int HALF = 10;
  localparam int Q    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_m = 1'b1;
  logic       app_busy = 1'b0;
  logic       sda_in, scl_in, sda_out, scl_out;
  logic       wr_en, bus_active;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  int n_chk = 0;
  int n_fail = 0;
  int sda_low = 0;
  logic [11:0] wlog[$];

  always #5 clk = ~clk;

  assign sda_in  = sda_m & sda_out;
  assign scl_in  = scl_m & scl_out;
  assign rd_data = {4'h1, rd_addr};

  i2c_slave_regfile dut (
    .clk(clk), .rst(rst),
    .sda_in(sda_in), .scl_in(scl_in),
    .sda_out(sda_out), .scl_out(scl_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .app_busy(app_busy), .bus_active(bus_active)
  );

  always @(posedge clk) begin
    if (wr_en) wlog.push_back({wr_addr, wr_data});
    if (!sda_out) sda_low <= sda_low + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] wl(input int i);
    if (i < wlog.size()) return wlog[i];
    return 12'hfff;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_up();
    scl_m = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (scl_in) break;
    end
    if (!scl_in) chk("scl_release_timeout", scl_in, 1);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clks(Q);
    scl_up();
    wait_clks(HALF);
    sda_m = 1'b0;
    wait_clks(HALF);
    scl_m = 1'b0;
    wait_clks(HALF - Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clks(Q);
    scl_up();
    wait_clks(HALF);
    sda_m = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    wait_clks(Q);
    scl_up();
    wait_clks(HALF);
    scl_m = 1'b0;
    wait_clks(HALF - Q);
  endtask

  // Ends right after SCL is pulled low, so callers can watch stretching
  task automatic get_ack(output logic a);
    sda_m = 1'b1;
    wait_clks(Q);
    scl_up();
    wait_clks(HALF / 2);
    a = sda_in;
    wait_clks(HALF - HALF / 2);
    scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_ack(a);
    wait_clks(HALF - Q);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clks(Q);
      scl_up();
      wait_clks(HALF / 2);
      b[i] = sda_in;
      wait_clks(HALF - HALF / 2);
      scl_m = 1'b0;
      wait_clks(HALF - Q);
    end
    send_bit(nack);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a;
    logic [7:0] b;
    int         w0, s0, lows, first;

    wait_clks(3);
    chk("rst_sda_out", sda_out, 1);
    chk("rst_scl_out", scl_out, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_bus_active", bus_active, 0);
    chk("rst_pointer", rd_addr, 0);
    rst = 1'b0;
    wait_clks(5);

    // write burst: pointer 3, data A5, 5A
    w0 = wlog.size();
    i2c_start();
    chk("wb_active", bus_active, 1);
    send_byte(8'h84, a); chk("wb_ack_addr", a, 0);
    send_byte(8'h03, a); chk("wb_ack_ptr", a, 0);
    send_byte(8'hA5, a); chk("wb_ack_d0", a, 0);
    send_byte(8'h5A, a); chk("wb_ack_d1", a, 0);
    i2c_stop();
    chk("wb_wr_count", wlog.size() - w0, 2);
    chk("wb_wr0", wl(w0), 12'h3A5);
    chk("wb_wr1", wl(w0 + 1), 12'h45A);
    chk("wb_pointer", rd_addr, 5);
    chk("wb_inactive", bus_active, 0);

    // read with repeated START across the 15 -> 0 wrap
    i2c_start();
    send_byte(8'h84, a); chk("rd_ack_addr", a, 0);
    send_byte(8'h0F, a); chk("rd_ack_ptr", a, 0);
    i2c_start();
    send_byte(8'h85, a); chk("rd_ack_addr_r", a, 0);
    read_byte(1'b0, b); chk("rd_byte0", b, 8'h1F);
    chk("rd_ptr_wrap", rd_addr, 0);
    read_byte(1'b1, b); chk("rd_byte1", b, 8'h10);
    wait_clks(3);
    chk("rd_sda_released", sda_out, 1);
    i2c_stop();
    chk("rd_ptr_final", rd_addr, 0);

    // wrong address: never acknowledged, never written
    w0 = wlog.size();
    s0 = sda_low;
    i2c_start();
    send_byte(8'h86, a); chk("wa_nack_addr", a, 1);
    send_byte(8'h00, a); chk("wa_nack_data", a, 1);
    chk("wa_sda_low_cycles", sda_low - s0, 0);
    chk("wa_active", bus_active, 1);
    i2c_stop();
    chk("wa_wr_count", wlog.size() - w0, 0);
    chk("wa_inactive", bus_active, 0);

    // STOP in the middle of a data byte
    i2c_start();
    send_byte(8'h84, a); chk("ab_ack_addr", a, 0);
    send_byte(8'h09, a); chk("ab_ack_ptr", a, 0);
    w0 = wlog.size();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    wait_clks(3);
    chk("ab_wr_count", wlog.size() - w0, 0);
    chk("ab_pointer", rd_addr, 9);
    chk("ab_inactive", bus_active, 0);
    chk("ab_sda_released", sda_out, 1);

    // clock stretching after the pointer ACK
    i2c_start();
    send_byte(8'h84, a); chk("st_ack_addr", a, 0);
    app_busy = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit(i == 2 || i == 1);
    get_ack(a); chk("st_ack_ptr", a, 0);
    lows = 0;
    first = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (!scl_out) begin
        lows++;
        if (first == 0) first = i;
      end
      if (i == 41) app_busy = 1'b0;
    end
    chk("st_low_cycles", lows, 40);
    chk("st_first_low", first, 2);
    chk("st_released", scl_out, 1);
    wait_clks(HALF - Q);
    w0 = wlog.size();
    send_byte(8'hC3, a); chk("st_ack_data", a, 0);
    i2c_stop();
    chk("st_wr", wl(w0), 12'h6C3);
    chk("st_pointer", rd_addr, 7);

    // async reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 2);
    chk("ar_ack_driven", sda_out, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_sda_async", sda_out, 1);
    chk("ar_scl_async", scl_out, 1);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(5);
    chk("ar_pointer", rd_addr, 0);
    chk("ar_inactive", bus_active, 0);
    i2c_start();
    send_byte(8'h85, a); chk("ar_ack_addr", a, 0);
    read_byte(1'b1, b); chk("ar_read_reg0", b, 8'h10);
    i2c_stop();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Parametrised I2C target (slave) with an explicit bit/byte FSM, replacing the ROM-sequenced single-port target.
- Adds a programmable 7-bit address, a register pointer with auto-increment, multi-byte write and read bursts, optional clock stretching and input synchronisers of configurable depth.
- Sits between the open-drain pad logic (SDA/SCL) and a local register bank owned by the application.

Parameters:
- SLV_ADDR, 7'h42, 7-bit target address matched after START.
- NREGS, 16, number of addressable registers. Power of two, 2..256.
- SYNC, 2, synchroniser flop count on sda_in/scl_in (>=2).
- STRETCH_EN, 1, when 1, scl_out is held low while app_busy is asserted.

Ports:
- clk  in  1  system clock, >= 8x SCL rate.
- rst  in  1  asynchronous active-high reset.
- sda_in  in  1  SDA pad level.
- scl_in  in  1  SCL pad level.
- sda_out  out  1  0 = pull SDA low, 1 = release.
- scl_out  out  1  0 = pull SCL low (stretch), 1 = release.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  $clog2(NREGS)  write register index.
- wr_data  out  8  write data.
- rd_addr  out  $clog2(NREGS)  current pointer, presented continuously.
- rd_data  in  8  register contents for rd_addr; must be valid within 1 clk of an rd_addr change.
- app_busy  in  1  request to stretch SCL.
- bus_active  out  1  high from START until STOP.

Behaviour:
- Reset values (async, rst=1):
  - sda_out=1, scl_out=1, wr_en=0, bus_active=0.
  - pointer=0, state=IDLE, bit counter=0.
- Synchronisers: SYNC flops on each input. scl_rise, scl_fall and sda edges are detected on the last two sync stages. All internal decisions use the synchronised values.
- START: SDA falls while SCL is high, in any state. Sets bus_active=1, goes to ADDR and clears the bit counter. A repeated START behaves the same way; the pointer is kept.
- STOP: SDA rises while SCL is high. Goes to IDLE, sets bus_active=0 and releases sda_out.
- Bit timing:
  - Receive bits are shifted in MSB-first on scl_rise.
  - sda_out changes only on the clk after scl_fall.
  - The bit counter wraps after 9 bits (8 data + ACK).
- States:
  - IDLE: all outputs released. Waits for START.
  - ADDR: shift 8 bits. On the 8th scl_rise, if byte[7:1]==SLV_ADDR go to ADDR_ACK; otherwise go to IDLE (ignore the bus until the next START).
  - ADDR_ACK: drive sda_out=0 for the 9th bit. On the following scl_fall, R/W=0 goes to PTR and R/W=1 goes to RD_BYTE.
  - PTR: first write byte. pointer <= byte mod NREGS, ACK, then go to WR_BYTE.
  - WR_BYTE: after 8 bits, pulse wr_en for one clk with wr_addr=pointer and wr_data=byte. ACK, then pointer <= pointer+1 mod NREGS.
  - RD_BYTE: on entry (scl_fall), load the shift register from rd_data and drive bits MSB-first. On the 9th scl_rise, sample the master ACK: SDA=0 means pointer+1 and stay in RD_BYTE; SDA=1 (NACK) means go to WAIT_STOP with sda_out released.
  - WAIT_STOP: no drive. Exits only on STOP or START.
- Stretching, when STRETCH_EN=1:
  - After any ACK bit's scl_fall, scl_out=0 while app_busy=1. Released on the first clk app_busy=0.
  - SCL is never pulled low while SCL is synchronously high.
  - When STRETCH_EN=0, scl_out is tied to 1.
- Boundaries:
  - Pointer wraps NREGS-1 -> 0 on both writes and reads.
  - Pointer byte >= NREGS is taken modulo NREGS.
  - START/STOP detected mid-byte aborts the byte: no wr_en, and the pointer is unchanged.
  - A START and the final scl edge in the same clk: START wins.
  - rst mid-transfer releases both lines immediately (asynchronously).

Test Plan:
- Write burst: START, 0x84, 0x03, 0xA5, 0x5A, STOP -> ACK on all 4 bytes. wr_en pulses twice with (3, A5) then (4, 5A). Final pointer=5.
- Read with repeated START: START 0x84, 0x0F, Sr 0x85, read 2 bytes (ACK, NACK) with rd_data model reg[i]=i+0x10 -> bytes 0x1F, 0x10 (pointer wraps 15 -> 0). sda released after NACK.
- Wrong address: START, 0x86, 0x00 -> no ACK (sda_out stays 1 for all 18 bits), wr_en never asserted, bus_active=1 until STOP.
- Abort: STOP after 4 bits of a data byte -> no wr_en, pointer unchanged, state IDLE, bus_active=0.
- Stretch: app_busy=1 for 40 clk after the ACK of the pointer byte -> scl_out=0 for exactly 40 clk starting 1 clk after scl_fall, then released. Next byte is received correctly.
- Async reset mid-ACK (sda_out=0) -> sda_out=1 and scl_out=1 in the same cycle rst rises; the next transaction after reset is accepted with pointer=0.
